rtp_result_collector: RTL
=========================

# rtp_result_collector

Downstream stage of the ray-traversal processor core. Accepts per-ray traversal results (ray id, hitT, hitIndex) over a valid/ready stream and buffers them in a small FIFO. Writes each result into the result memory at address = ray id, and tracks hit/miss/cycle statistics. Raises `done` once every ray of the launched batch has been written back; the testbench and host-side checker use this signal.

## Interface
Parameters:
- `RAY_ID_W`, 16, ray id width; result-memory address width.
- `FIFO_DEPTH`, 4, result buffer entries (power of two, ≥2).

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle launch pulse; honoured only in IDLE or DONE.
- `num_rays`  in  RAY_ID_W  batch size, sampled on accepted `start`.
- `res_valid`  in  1  core presents a result.
- `res_ready`  out  1  collector accepts the result this cycle.
- `res_ray_id`  in  RAY_ID_W  ray id of the result.
- `res_hitT`  in  32  IEEE-754 hit distance, passed through untouched.
- `res_hitIndex`  in  32  triangle index; 32'hFFFFFFFF means miss.
- `mem_wr_en`  out  1  result-memory write request.
- `mem_wr_ready`  in  1  memory accepts the write this cycle.
- `mem_wr_addr`  out  RAY_ID_W  = ray id.
- `mem_wr_data`  out  64  {hitIndex, hitT}.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  high in DONE state.
- `hit_count`, `miss_count`  out  RAY_ID_W  counts of written-back results.
- `cycle_count`  out  32  cycles spent in RUN+DRAIN; saturates at all-ones.
- `dup_err`  out  1  sticky; a ray id was accepted twice in the batch.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + `start`:
  - latch `num_rays`; clear the counters, `dup_err`, the accepted count and the seen-bitmap.
  - go to RUN, or straight to DONE if `num_rays`==0.
- RUN: `res_ready` = !fifo_full. A handshake (`res_valid`&&`res_ready`) pushes the result and increments `accepted`. When the push makes `accepted`==`num_rays`, go to DRAIN.
- DRAIN: `res_ready`=0. Go to DONE in the cycle the last FIFO entry is written, i.e. the FIFO becomes empty on that cycle's pop.
- `res_ready`=0 in IDLE, DRAIN and DONE. Results offered in those states are stalled, never dropped.
- Write-back: `mem_wr_en` = !fifo_empty and state ∈ {RUN, DRAIN}. Address and data come from the FIFO head. A pop occurs on `mem_wr_en`&&`mem_wr_ready`.
- On each pop: if hitIndex==32'hFFFFFFFF, `miss_count`++, else `hit_count`++.
- Duplicate detection uses a 2^RAY_ID_W-bit seen-bitmap implemented as a flag RAM, cleared by a counter sweep after `start`:
  - during the sweep the state stays RUN but `res_ready`=0;
  - the sweep takes 2^RAY_ID_W cycles, and those cycles count in `cycle_count`;
  - an accepted id whose bit is already set sets `dup_err`; the result is still written.
- Ray ids ≥ `num_rays` are accepted and written with no check.
- Reset mid-operation returns to IDLE immediately. The FIFO is emptied and every output returns to its reset value.

## Timing
- Reset values: `res_ready`=0, `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `busy`=0, `done`=0, all counters 0, `dup_err`=0.
- FIFO is registered and show-ahead. A result accepted at edge N is presented on `mem_wr_*` from cycle N+1, giving a minimum latency of 1 cycle.
- With `mem_wr_ready` held high, throughput is 1 result/cycle.
- Full FIFO: `res_ready`=0 even if a pop happens in the same cycle (no bypass). Ready reasserts the cycle after the pop.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged.
- `done` rises the cycle after the final write handshake and holds until the next accepted `start`.
- `cycle_count` increments on every clock in RUN or DRAIN and freezes in DONE.

## Structure
- Shared package `rtp_pkg`:
  - `RAY_ID_W` default;
  - `MISS_INDEX` = 32'hFFFFFFFF;
  - packed `rtp_result_t` {ray_id, hitIndex, hitT};
  - state enum `collector_state_e`.
- Sub-module `rtp_result_fifo`: parameterised sync FIFO of `rtp_result_t`, async active-high reset, `full`/`empty` outputs, show-ahead read.
- Top contains the FSM, counters, seen-bitmap and clear sweep.

## Test plan
- `num_rays`=4, ids 0..3 back-to-back, `mem_wr_ready`=1 → four writes at addr 0..3 on consecutive cycles after the sweep; `done`=1 one cycle after the 4th write.
- Two hits and two misses (hitIndex 5, FFFFFFFF, 9, FFFFFFFF) → `hit_count`=2, `miss_count`=2, `mem_wr_data`[63:32] matches each result.
- `mem_wr_ready`=0 for 10 cycles with continuous `res_valid` → exactly FIFO_DEPTH (4) accepted, `res_ready`=0 afterwards; no loss or reordering after release.
- Ids 2, 2 with `num_rays`=2 → `dup_err`=1 after the second accept; both writes still occur; `done`=1.
- `start` with `num_rays`=0 → DONE next cycle; no `mem_wr_en`; `cycle_count`=0.
- `reset` asserted mid-DRAIN with 2 entries queued → next cycle `mem_wr_en`=0, `busy`=0 and all counters 0; a new `start` then runs a clean batch.

Source files
------------

// File: rtl/rtp_pkg.sv
// rtl/rtp_pkg.sv - shared types and constants for the ray-traversal result path
//
// Purpose: default ray id width, miss marker, the packed result record and the
//          collector state encoding.
package rtp_pkg;

   localparam int RAY_ID_W = 16;

   // hitIndex value reported by the core when a ray hits nothing
   localparam logic [31:0] MISS_INDEX = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [RAY_ID_W-1:0] ray_id;
      logic [31:0]         hitIndex;
      logic [31:0]         hitT;
   } rtp_result_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } collector_state_e;

endpackage

// File: rtl/rtp_result_fifo.sv
// rtl/rtp_result_fifo.sv - registered show-ahead sync FIFO of result records
//
// Purpose: buffers results between the core and the result-memory port.
// Ports:
//   clock, reset      clock; asynchronous active-high reset (empties the FIFO)
//   i_push, i_data    write request and entry; ignored while full
//   i_pop             read request; ignored while empty
//   o_data            head entry (valid whenever !o_empty)
//   o_full, o_empty   occupancy flags
//   o_one             exactly one entry held
module rtp_result_fifo
   import rtp_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = rtp_result_t
) (
   input  logic clock,
   input  logic reset,
   input  logic i_push,
   input  T     i_data,
   input  logic i_pop,
   output T     o_data,
   output logic o_full,
   output logic o_empty,
   output logic o_one
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   T            r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_one   = ((r_wr_ptr - r_rd_ptr) == (AW+1)'(1));
   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: entries are only observed between push and pop.
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/rtp_result_collector.sv
// rtl/rtp_result_collector.sv - collects traversal results and writes them to result memory
//
// Purpose: accepts per-ray results, buffers them, writes each to address = ray id,
//          keeps hit/miss/cycle statistics, flags duplicate ids and signals batch done.
// Ports:
//   clock, reset                          clock; asynchronous active-high reset
//   start, num_rays                       batch launch pulse and batch size
//   res_valid/res_ready, res_ray_id,
//   res_hitT, res_hitIndex                incoming result stream
//   mem_wr_en/mem_wr_ready,
//   mem_wr_addr, mem_wr_data              result-memory write port, data = {hitIndex, hitT}
//   busy, done                            RUN/DRAIN and DONE indicators
//   hit_count, miss_count, cycle_count    statistics of the current batch
//   dup_err                               sticky duplicate-id flag
module rtp_result_collector
   import rtp_pkg::*;
#(
   parameter int RAY_ID_W   = rtp_pkg::RAY_ID_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [RAY_ID_W-1:0] num_rays,
   input  logic                res_valid,
   output logic                res_ready,
   input  logic [RAY_ID_W-1:0] res_ray_id,
   input  logic [31:0]         res_hitT,
   input  logic [31:0]         res_hitIndex,
   output logic                mem_wr_en,
   input  logic                mem_wr_ready,
   output logic [RAY_ID_W-1:0] mem_wr_addr,
   output logic [63:0]         mem_wr_data,
   output logic                busy,
   output logic                done,
   output logic [RAY_ID_W-1:0] hit_count,
   output logic [RAY_ID_W-1:0] miss_count,
   output logic [31:0]         cycle_count,
   output logic                dup_err
);

   // Same layout as rtp_result_t, sized by this instance's id width.
   typedef struct packed {
      logic [RAY_ID_W-1:0] ray_id;
      logic [31:0]         hitIndex;
      logic [31:0]         hitT;
   } result_t;

   collector_state_e    r_state;
   logic [RAY_ID_W-1:0] r_num_rays;
   logic [RAY_ID_W-1:0] r_accepted;
   logic [RAY_ID_W-1:0] r_sweep_cnt;
   logic                r_sweeping;
   logic [RAY_ID_W-1:0] r_hit_count;
   logic [RAY_ID_W-1:0] r_miss_count;
   logic [31:0]         r_cycle_count;
   logic                r_dup_err;
   logic                r_seen [0:(1<<RAY_ID_W)-1];

   result_t w_in;
   result_t w_head;
   logic    w_full;
   logic    w_empty;
   logic    w_one;
   logic    w_push;
   logic    w_pop;
   logic    w_active;
   logic    w_seen_hit;

   assign w_in       = '{ray_id: res_ray_id, hitIndex: res_hitIndex, hitT: res_hitT};
   assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   // No bypass: a full FIFO refuses input even if it pops this cycle.
   assign res_ready  = (r_state == ST_RUN) && !r_sweeping && !w_full;
   assign w_push     = res_valid && res_ready;
   assign mem_wr_en  = w_active && !w_empty;
   assign w_pop      = mem_wr_en && mem_wr_ready;
   assign mem_wr_addr = mem_wr_en ? w_head.ray_id : '0;
   assign mem_wr_data = mem_wr_en ? {w_head.hitIndex, w_head.hitT} : '0;
   assign w_seen_hit = r_seen[res_ray_id];

   assign busy        = w_active;
   assign done        = (r_state == ST_DONE);
   assign hit_count   = r_hit_count;
   assign miss_count  = r_miss_count;
   assign cycle_count = r_cycle_count;
   assign dup_err     = r_dup_err;

   rtp_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (result_t)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_in),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_one   (w_one)
   );

   // Seen-bitmap flag RAM: swept clear after each launch, marked on accept.
   // The sweep holds res_ready low, so the two write sources never collide.
   always_ff @(posedge clock) begin
      if (r_sweeping)  r_seen[r_sweep_cnt] <= 1'b0;
      else if (w_push) r_seen[res_ray_id]  <= 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_num_rays    <= '0;
         r_accepted    <= '0;
         r_sweep_cnt   <= '0;
         r_sweeping    <= 1'b0;
         r_hit_count   <= '0;
         r_miss_count  <= '0;
         r_cycle_count <= '0;
         r_dup_err     <= 1'b0;
      end else begin
         if (w_active && (r_cycle_count != '1)) r_cycle_count <= r_cycle_count + 32'd1;

         if (w_pop) begin
            if (w_head.hitIndex == MISS_INDEX) r_miss_count <= r_miss_count + RAY_ID_W'(1);
            else                               r_hit_count  <= r_hit_count + RAY_ID_W'(1);
         end

         if (w_push) begin
            r_accepted <= r_accepted + RAY_ID_W'(1);
            if (w_seen_hit) r_dup_err <= 1'b1;
         end

         if (r_sweeping) begin
            r_sweep_cnt <= r_sweep_cnt + RAY_ID_W'(1);
            if (r_sweep_cnt == '1) r_sweeping <= 1'b0;
         end

         unique case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_num_rays    <= num_rays;
                  r_accepted    <= '0;
                  r_hit_count   <= '0;
                  r_miss_count  <= '0;
                  r_cycle_count <= '0;
                  r_dup_err     <= 1'b0;
                  r_sweep_cnt   <= '0;
                  r_sweeping    <= (num_rays != '0);
                  r_state       <= (num_rays == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_push && ((r_accepted + RAY_ID_W'(1)) == r_num_rays)) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Leave when the final buffered entry is written.
               if (w_pop && w_one) r_state <= ST_DONE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
